// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser feeding a counter-based debounce FSM.
// Produces a debounced level plus one-cycle press, release and long-press strobes.
module btn_debounce #(
   parameter int          COUNT_WIDTH       = 32,
   parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
   parameter int unsigned LONG_PRESS_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press_pulse
);

   localparam logic [COUNT_WIDTH-1:0] DEB_LAST  = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [COUNT_WIDTH-1:0] LONG_LAST = COUNT_WIDTH'(LONG_PRESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t                 state;
   logic                   s1;
   logic                   s2;
   logic                   fired;
   logic [COUNT_WIDTH-1:0] cnt;
   logic [COUNT_WIDTH-1:0] hold;

   // NOTE: sequential state uses non-blocking assignments so s2 takes the old s1,
   // giving a true two-stage synchroniser rather than a single collapsed flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         hold             <= '0;
         fired            <= 1'b0;
         btn_level        <= 1'b0;
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;
      end else begin
         // Strobes default low so each one lasts exactly a single cycle.
         press_pulse      <= 1'b0;
         release_pulse    <= 1'b0;
         long_press_pulse <= 1'b0;

         case (state)
            IDLE: begin
               btn_level <= 1'b0;
               if (s2) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end

            PRESS_WAIT: begin
               if (!s2) begin
                  state <= IDLE;
               end else if (cnt == DEB_LAST) begin
                  state       <= PRESSED;
                  btn_level   <= 1'b1;
                  press_pulse <= 1'b1;
                  hold        <= '0;
                  fired       <= 1'b0;
               end else begin
                  cnt <= cnt + COUNT_WIDTH'(1);
               end
            end

            PRESSED: begin
               if (!s2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end else if (!fired) begin
                  // hold parks at its terminal value once fired, so it never wraps.
                  if (hold == LONG_LAST) begin
                     long_press_pulse <= 1'b1;
                     fired            <= 1'b1;
                  end else begin
                     hold <= hold + COUNT_WIDTH'(1);
                  end
               end
            end

            RELEASE_WAIT: begin
               if (s2) begin
                  state <= PRESSED;
               end else if (cnt == DEB_LAST) begin
                  state         <= IDLE;
                  btn_level     <= 1'b0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + COUNT_WIDTH'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a run-length behavioural model checked every cycle,
// plus directed latency and strobe-count checks with hand-computed values.
module tb_btn_debounce;

   localparam int unsigned D = 4;
   localparam int unsigned L = 10;

   logic clk;
   logic reset;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press_pulse;

   int total = 0;
   int bad   = 0;
   int n_press = 0;
   int n_rel   = 0;
   int n_long  = 0;

   btn_debounce #(
      .COUNT_WIDTH      (32),
      .DEBOUNCE_CYCLES  (D),
      .LONG_PRESS_CYCLES(L)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .btn_in          (btn_in),
      .btn_level       (btn_level),
      .press_pulse     (press_pulse),
      .release_pulse   (release_pulse),
      .long_press_pulse(long_press_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Model: the accepted level flips once the synchronised input has disagreed with
   // it for D+1 consecutive samples; a long press needs L steadily-held samples.
   typedef struct packed {
      logic        s1;
      logic        s2;
      logic        lvl;
      logic        press;
      logic        rel;
      logic        lng;
      logic        fired;
      int unsigned run;
      int unsigned hold;
   } mdl_t;

   mdl_t m = '0;

   function automatic mdl_t step(input mdl_t cur, input logic rst, input logic b);
      mdl_t nxt = cur;
      if (rst) return '0;
      nxt.s1    = b;
      nxt.s2    = cur.s1;
      nxt.press = 1'b0;
      nxt.rel   = 1'b0;
      nxt.lng   = 1'b0;
      if (cur.s2 != cur.lvl) begin
         nxt.run = cur.run + 1;
         if (nxt.run == D + 1) begin
            nxt.lvl = cur.s2;
            nxt.run = 0;
            if (cur.s2) begin
               nxt.press = 1'b1;
               nxt.hold  = 0;
               nxt.fired = 1'b0;
            end else begin
               nxt.rel = 1'b1;
            end
         end
      end else begin
         nxt.run = 0;
         if (cur.lvl && cur.run == 0 && !cur.fired) begin
            nxt.hold = cur.hold + 1;
            if (nxt.hold == L) begin
               nxt.lng   = 1'b1;
               nxt.fired = 1'b1;
            end
         end
      end
      return nxt;
   endfunction

   always @(posedge clk) m <= step(m, reset, btn_in);

   always @(negedge clk) begin
      check("cycle_outs",
            int'({btn_level, press_pulse, release_pulse, long_press_pulse}),
            int'({m.lvl, m.press, m.rel, m.lng}));
      if (press_pulse === 1'b1)      n_press++;
      if (release_pulse === 1'b1)    n_rel++;
      if (long_press_pulse === 1'b1) n_long++;
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until the selected strobe is seen; -1 if the budget runs out.
   task automatic wait_for(input int sel, input int budget, output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if ((sel == 0 && press_pulse === 1'b1) ||
             (sel == 1 && release_pulse === 1'b1) ||
             (sel == 2 && long_press_pulse === 1'b1)) begin
            n = i;
            break;
         end
      end
   endtask

   int n;

   initial begin
      reset  = 1'b1;
      btn_in = 1'b0;

      // Reset with button released, then a quiet interval.
      tick(3);
      check("reset_outs", int'({btn_level, press_pulse, release_pulse, long_press_pulse}), 0);
      reset = 1'b0;
      tick(20);
      check("quiet_strobes", n_press + n_rel + n_long, 0);

      // Clean press: strobe 7 edges after the input changes.
      btn_in = 1'b1;
      wait_for(0, 20, n);
      check("press_lat", n, 7);
      check("level_after_press", int'(btn_level), 1);

      // Held long: one long-press strobe 10 edges after press, then clean release.
      wait_for(2, 20, n);
      check("long_lat", n, 10);
      tick(20);
      check("long_once", n_long, 1);
      btn_in = 1'b0;
      wait_for(1, 20, n);
      check("release_lat", n, 7);
      tick(1);
      check("level_after_release", int'(btn_level), 0);

      // Bouncy input never stable long enough to be accepted.
      for (int r = 0; r < 5; r++) begin
         btn_in = 1'b1;
         tick(3);
         btn_in = 1'b0;
         tick(1);
      end
      tick(10);
      check("bounce_no_press", n_press, 1);
      check("bounce_level", int'(btn_level), 0);

      // Release glitch while pressed: no release, long press delayed by 3 edges.
      btn_in = 1'b1;
      wait_for(0, 20, n);
      check("press_lat2", n, 7);
      tick(3);
      btn_in = 1'b0;
      tick(2);
      btn_in = 1'b1;
      wait_for(2, 30, n);
      check("long_lat_glitch", n, 13 - 5);
      check("glitch_no_release", n_rel, 1);
      btn_in = 1'b0;
      wait_for(1, 20, n);
      check("release_lat2", n, 7);

      // Reset during PRESS_WAIT with button held, then fresh press after reset.
      btn_in = 1'b1;
      tick(4);
      reset = 1'b1;
      tick(1);
      check("rst_wait_outs", int'({btn_level, press_pulse, release_pulse, long_press_pulse}), 0);
      tick(1);
      reset = 1'b0;
      wait_for(0, 20, n);
      check("press_after_rst1", n, 7);

      // Reset while PRESSED drops the level at once; held button re-presses.
      tick(2);
      reset = 1'b1;
      tick(1);
      check("rst_pressed_outs", int'({btn_level, press_pulse, release_pulse, long_press_pulse}), 0);
      reset = 1'b0;
      wait_for(0, 20, n);
      check("press_after_rst2", n, 7);
      btn_in = 1'b0;
      wait_for(1, 20, n);
      check("release_lat3", n, 7);
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
